// File: rtl/nf_i_fetch_if.sv
// Instruction-fetch bundle: memory request/response, decode handoff and branch redirect.
// master = fetch unit, slave = the environment (memory, decode, branch unit).
interface nf_i_fetch_if;
  logic        req_o;
  logic [31:0] addr_o;
  logic        ack_i;
  logic [31:0] rd_data_i;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        branch_take_i;
  logic [31:0] branch_addr_i;
  logic        misalign_o;

  modport master (
    output req_o, addr_o, instr_o, opcode_o, funct3_o, funct7_o, pc_o,
           instr_valid_o, misalign_o,
    input  ack_i, rd_data_i, instr_ready_i, branch_take_i, branch_addr_i
  );

  modport slave (
    input  req_o, addr_o, instr_o, opcode_o, funct3_o, funct7_o, pc_o,
           instr_valid_o, misalign_o,
    output ack_i, rd_data_i, instr_ready_i, branch_take_i, branch_addr_i
  );
endinterface

// File: rtl/nf_i_fetch.sv
// Single-buffer instruction fetch unit with branch redirect and in-flight discard.
// Optional misaligned-target pulse enabled by defining NF_IF_MISALIGN_EN.
module nf_i_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  nf_i_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target;

  assign target = {bus.branch_addr_i[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    old_pc_d   = old_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    case (state_q)
      FETCH: begin
        if (bus.branch_take_i) begin
          fetch_pc_d = target;
          // Without ack the request is already on the bus and must complete at its old address.
          if (!bus.ack_i) begin
            old_pc_d = fetch_pc_q;
            state_d  = DISCARD;
          end
        end else if (bus.ack_i) begin
          instr_d    = bus.rd_data_i;
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.branch_take_i) begin
          fetch_pc_d = target;
          state_d    = FETCH;
        end else if (bus.instr_ready_i) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (bus.branch_take_i) fetch_pc_d = target;
        if (bus.ack_i) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      old_pc_q   <= RESET_PC;
      instr_q    <= 32'd0;
      pc_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      old_pc_q   <= old_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Handshake outputs are masked by rst so nothing is requested or offered during reset.
  assign bus.req_o         = !rst && (state_q != HOLD);
  assign bus.addr_o        = (state_q == DISCARD) ? old_pc_q : fetch_pc_q;
  assign bus.instr_valid_o = !rst && (state_q == HOLD);
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.opcode_o      = instr_q[6:0];
  assign bus.funct3_o      = instr_q[14:12];
  assign bus.funct7_o      = instr_q[31:25];

`ifdef NF_IF_MISALIGN_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = bus.branch_take_i && (bus.branch_addr_i[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign bus.misalign_o = misalign_q;
`else
  assign bus.misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_nf_i_fetch.sv
// Directed table-driven bench for nf_i_fetch; second instance covers PC wrap from 32'hFFFF_FFFC.
module tb_nf_i_fetch;

`ifdef NF_IF_MISALIGN_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nf_i_fetch_if bus0 ();
  nf_i_fetch_if bus1 ();

  nf_i_fetch #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  nf_i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Wrap instance: zero-wait memory, always-ready decode, no branches.
  assign bus1.ack_i         = 1'b1;
  assign bus1.rd_data_i     = 32'h0000_0013;
  assign bus1.instr_ready_i = 1'b1;
  assign bus1.branch_take_i = 1'b0;
  assign bus1.branch_addr_i = 32'd0;

  typedef struct {
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        br;
    logic [31:0] ba;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I0 = 32'h1111_1113;
  localparam logic [31:0] I1 = 32'h2222_2223;
  localparam logic [31:0] I2 = 32'h00A0_0093;
  localparam logic [31:0] I3 = 32'h0050_0113;
  localparam logic [31:0] I4 = 32'h4020_8033;
  localparam logic [31:0] I5 = 32'hFE31_4AB3;
  localparam logic [31:0] I6 = 32'h0010_0073;

  function automatic vec_t mk(logic ack, logic [31:0] rd, logic rdy, logic br, logic [31:0] ba,
                              logic e_req, logic [31:0] e_addr, logic e_val,
                              logic [31:0] e_pc, logic [31:0] e_instr, logic e_mis);
    vec_t v;
    v.ack = ack; v.rd = rd; v.rdy = rdy; v.br = br; v.ba = ba;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic ack, logic [31:0] rd, logic rdy, logic br, logic [31:0] ba);
    bus0.ack_i         = ack;
    bus0.rd_data_i     = rd;
    bus0.instr_ready_i = rdy;
    bus0.branch_take_i = br;
    bus0.branch_addr_i = ba;
  endtask

  initial begin
    //            ack rd          rdy br ba            req addr          val pc            instr mis
    vt[0]  = mk(1, I0,          1, 0, 32'h0,     1, 32'h0,     0, 32'h0,   32'h0, 0);
    vt[1]  = mk(0, 32'h0,       1, 0, 32'h0,     0, 32'h0,     1, 32'h0,   I0,    0);
    vt[2]  = mk(1, I1,          1, 0, 32'h0,     1, 32'h4,     0, 32'h0,   I0,    0);
    vt[3]  = mk(0, 32'h0,       1, 0, 32'h0,     0, 32'h0,     1, 32'h4,   I1,    0);
    vt[4]  = mk(1, I2,          1, 0, 32'h0,     1, 32'h8,     0, 32'h4,   I1,    0);
    vt[5]  = mk(1, 32'h5555,    0, 0, 32'h0,     0, 32'h0,     1, 32'h8,   I2,    0);
    vt[6]  = mk(1, 32'h5555,    0, 0, 32'h0,     0, 32'h0,     1, 32'h8,   I2,    0);
    vt[7]  = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'h0,     1, 32'h8,   I2,    0);
    vt[8]  = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'h0,     1, 32'h8,   I2,    0);
    vt[9]  = mk(0, 32'h0,       0, 0, 32'h0,     0, 32'h0,     1, 32'h8,   I2,    0);
    vt[10] = mk(0, 32'h0,       1, 0, 32'h0,     0, 32'h0,     1, 32'h8,   I2,    0);
    vt[11] = mk(0, 32'h0,       0, 1, 32'h140,   1, 32'hC,     0, 32'h8,   I2,    0);
    vt[12] = mk(0, 32'h0,       0, 1, 32'h100,   1, 32'hC,     0, 32'h8,   I2,    0);
    vt[13] = mk(0, 32'h0,       0, 0, 32'h0,     1, 32'hC,     0, 32'h8,   I2,    0);
    vt[14] = mk(1, 32'hDEADBEEF,0, 0, 32'h0,     1, 32'hC,     0, 32'h8,   I2,    0);
    vt[15] = mk(1, I3,          0, 0, 32'h0,     1, 32'h100,   0, 32'h8,   I2,    0);
    vt[16] = mk(0, 32'h0,       1, 1, 32'h200,   0, 32'h0,     1, 32'h100, I3,    0);
    vt[17] = mk(0, 32'h0,       0, 0, 32'h0,     1, 32'h200,   0, 32'h100, I3,    0);
    vt[18] = mk(1, I4,          0, 1, 32'h300,   1, 32'h200,   0, 32'h100, I3,    0);
    vt[19] = mk(0, 32'h0,       0, 1, 32'h102,   1, 32'h300,   0, 32'h100, I3,    0);
    vt[20] = mk(1, 32'hCAFEF00D,0, 0, 32'h0,     1, 32'h300,   0, 32'h100, I3,    MIS_EN);
    vt[21] = mk(1, I5,          0, 0, 32'h0,     1, 32'h100,   0, 32'h100, I3,    0);
    vt[22] = mk(0, 32'h0,       1, 0, 32'h0,     0, 32'h0,     1, 32'h100, I5,    0);
    vt[23] = mk(0, 32'h0,       0, 0, 32'h0,     1, 32'h104,   0, 32'h100, I5,    0);

    drive(1, 32'hBAD0_BAD0, 1, 0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req",   {31'd0, bus0.req_o},         32'd0);
    chk("rst_valid", {31'd0, bus0.instr_valid_o}, 32'd0);
    chk("rst_instr", bus0.instr_o,                32'd0);
    chk("rst_pc",    bus0.pc_o,                   32'd0);
    chk("rst_mis",   {31'd0, bus0.misalign_o},    32'd0);
    chk("rst_req1",  {31'd0, bus1.req_o},         32'd0);

    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].ack, vt[i].rd, vt[i].rdy, vt[i].br, vt[i].ba);
      #1;
      chk($sformatf("r%0d_req", i),   {31'd0, bus0.req_o},         {31'd0, vt[i].e_req});
      if (vt[i].e_req)
        chk($sformatf("r%0d_addr", i), bus0.addr_o,                vt[i].e_addr);
      chk($sformatf("r%0d_valid", i), {31'd0, bus0.instr_valid_o}, {31'd0, vt[i].e_val});
      chk($sformatf("r%0d_pc", i),    bus0.pc_o,                   vt[i].e_pc);
      chk($sformatf("r%0d_instr", i), bus0.instr_o,                vt[i].e_instr);
      chk($sformatf("r%0d_fields", i),
          {15'd0, bus0.funct7_o, bus0.funct3_o, bus0.opcode_o},
          {15'd0, vt[i].e_instr[31:25], vt[i].e_instr[14:12], vt[i].e_instr[6:0]});
      chk($sformatf("r%0d_mis", i),   {31'd0, bus0.misalign_o},    {31'd0, vt[i].e_mis});
      if (i == 0) begin
        chk("wrap_req0",  {31'd0, bus1.req_o}, 32'd1);
        chk("wrap_addr0", bus1.addr_o,         32'hFFFF_FFFC);
      end
      if (i == 1) chk("wrap_pc0", bus1.pc_o, 32'hFFFF_FFFC);
      if (i == 2) begin
        chk("wrap_req1",  {31'd0, bus1.req_o}, 32'd1);
        chk("wrap_addr1", bus1.addr_o,         32'h0000_0000);
      end
      @(negedge clk);
    end

    // Reset with a request outstanding, then a late ack answers for RESET_PC.
    drive(0, 32'h0, 0, 0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst2_req",   {31'd0, bus0.req_o},         32'd0);
    chk("rst2_valid", {31'd0, bus0.instr_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, I6, 1, 0, 32'h0);
    #1;
    chk("post_req",   {31'd0, bus0.req_o}, 32'd1);
    chk("post_addr",  bus0.addr_o,         32'h0);
    chk("post_pc",    bus0.pc_o,           32'h0);
    chk("post_instr", bus0.instr_o,        32'h0);
    @(negedge clk);
    drive(0, 32'h0, 1, 0, 32'h0);
    #1;
    chk("post_valid",  {31'd0, bus0.instr_valid_o}, 32'd1);
    chk("post_instr2", bus0.instr_o,                I6);
    chk("post_pc2",    bus0.pc_o,                   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
